// File: rtl/pixel_pkg.sv
// pixel_pkg: shared widths, default weight scale and FSM state type for the pixel normalizers
package pixel_pkg;
  localparam int PIX_W = 8;
  localparam int PROD_W = 20;
  localparam int WEIGHT_W = 9;
  localparam int FRAC_BITS = 7;
  typedef enum logic {ACCUM, OUT} state_t;
endpackage

// File: rtl/pixel_round_clamp.sv
// pixel_round_clamp: round half up, arithmetic shift by FRAC_BITS, clamp to 0..255 with clip flag
module pixel_round_clamp
  import pixel_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int FRAC_BITS = pixel_pkg::FRAC_BITS
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic [PIX_W-1:0]        pixel,
  output logic                    clipped
);
  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] r;
  logic neg;
  logic big;
  // one extra bit of headroom so adding the rounding bias can never wrap
  always_comb begin
    biased = {sum[ACC_W-1], sum} + (ACC_W+1)'(2 ** (FRAC_BITS - 1));
    r = biased >>> FRAC_BITS;
    neg = r[ACC_W];
    big = !neg && (|r[ACC_W-1:PIX_W]);
    pixel = neg ? '0 : big ? '1 : r[PIX_W-1:0];
    clipped = neg | big;
  end
endmodule

// File: rtl/pixel_accum_normalize.sv
// pixel_accum_normalize: sums TAPS signed products per kernel and emits a rounded, clamped 8-bit pixel; PIXEL_ACCUM_CLIP_FLAG_EN adds out_clipped
module pixel_accum_normalize
  import pixel_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int FRAC_BITS = pixel_pkg::FRAC_BITS,
  parameter int ACC_W = 24,
  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic [IW-1:0]     tap_idx
`ifdef PIXEL_ACCUM_CLIP_FLAG_EN
  ,
  output logic              out_clipped
`endif
);
  state_t state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [PIX_W-1:0] pix;
  logic last;
`ifdef PIXEL_ACCUM_CLIP_FLAG_EN
  logic clip;
`else
  logic clip_unused;
`endif

  assign sum = acc + {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
  assign last = tap_idx == IW'(TAPS - 1);
  assign in_ready = state == ACCUM;
  assign out_valid = state == OUT;

  pixel_round_clamp #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)) u_round_clamp (
    .sum(sum),
    .pixel(pix),
`ifdef PIXEL_ACCUM_CLIP_FLAG_EN
    .clipped(clip)
`else
    .clipped(clip_unused)
`endif
  );

  // accumulate taps in ACCUM, latch the normalized pixel on the final tap, hold it in OUT until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc <= '0;
      tap_idx <= '0;
      out_pixel <= '0;
`ifdef PIXEL_ACCUM_CLIP_FLAG_EN
      out_clipped <= 1'b0;
`endif
    end else if (state == ACCUM) begin
      if (in_valid) begin
        if (last) begin
          acc <= '0;
          tap_idx <= '0;
          out_pixel <= pix;
`ifdef PIXEL_ACCUM_CLIP_FLAG_EN
          out_clipped <= clip;
`endif
          state <= OUT;
        end else begin
          acc <= sum;
          tap_idx <= tap_idx + 1'b1;
        end
      end
    end else if (out_ready) begin
      state <= ACCUM;
    end
  end
endmodule
